// File: rtl/fft_agu_sched.sv
// rtl/fft_agu_sched.sv - stage sequencer and address generator for the in-place radix-2 DIT FFT core
module fft_agu_sched #(
    parameter int LOG2N       = 5,
    parameter int PIPE_LAT    = 3,
    parameter int HAZARD_WAIT = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       mode,
    input  logic                       en,
    output logic                       busy,
    output logic                       rd_valid,
    output logic [LOG2N-1:0]           addr_A,
    output logic [LOG2N-1:0]           addr_B,
    output logic [LOG2N-2:0]           addr_Tw,
    output logic [$clog2(LOG2N)-1:0]   stage,
    output logic                       wr_en,
    output logic [LOG2N-1:0]           wr_addr_A,
    output logic [LOG2N-1:0]           wr_addr_B,
    output logic                       done
);

    localparam int SW = $clog2(LOG2N);
    localparam int TW = LOG2N - 1;
    localparam int DW = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state;
    logic             mode_q;
    logic [SW-1:0]    s;
    logic [LOG2N-1:0] j;
    logic [DW-1:0]    dcnt;

    logic [LOG2N-1:0] h;
    logic [LOG2N-1:0] h_mask;
    logic [LOG2N-1:0] fft_a;
    logic [LOG2N-1:0] fft_b;
    logic [TW-1:0]    fft_tw;
    logic [LOG2N-1:0] rev_j;
    logic [SW:0]      s_p1;
    logic [SW:0]      tw_sh;
    logic             j_last;
    logic             s_last;
    logic             d_last;

    logic             vld_sr [PIPE_LAT];
    logic [LOG2N-1:0] a_sr   [PIPE_LAT];
    logic [LOG2N-1:0] b_sr   [PIPE_LAT];

    // Butterfly / copy-pass address arithmetic from the stage and butterfly counters
    always_comb begin
        s_p1   = {1'b0, s} + (SW+1)'(1);
        tw_sh  = (SW+1)'(LOG2N - 1) - {1'b0, s};
        h      = LOG2N'(1) << s;
        h_mask = h - LOG2N'(1);
        fft_a  = ((j >> s) << s_p1) | (j & h_mask);
        fft_b  = fft_a + h;
        fft_tw = TW'(j & h_mask) << tw_sh;
        for (int i = 0; i < LOG2N; i++) begin
            rev_j[i] = j[LOG2N-1-i];
        end
        j_last = mode_q ? (j == '1) : (j == LOG2N'((1 << (LOG2N - 1)) - 1));
        s_last = (s == SW'(LOG2N - 1));
        d_last = (dcnt == DW'(PIPE_LAT - 1));
    end

    // Read-side outputs; addresses are forced to zero outside RUN
    always_comb begin
        rd_valid = (state == S_RUN);
        busy     = (state != S_IDLE);
        done     = (state == S_DONE);
        stage    = s;
        addr_A   = '0;
        addr_B   = '0;
        addr_Tw  = '0;
        if (rd_valid) begin
            addr_A  = mode_q ? j     : fft_a;
            addr_B  = mode_q ? rev_j : fft_b;
            addr_Tw = mode_q ? '0    : fft_tw;
        end
    end

    // Control FSM: walks stages and butterflies, drains the datapath between stages
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            mode_q <= 1'b0;
            s      <= '0;
            j      <= '0;
            dcnt   <= '0;
        end else if (en) begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_RUN;
                        mode_q <= mode;
                        s      <= '0;
                        j      <= '0;
                    end
                end
                S_RUN: begin
                    if (j_last) begin
                        if (mode_q || (HAZARD_WAIT != 0) || s_last) begin
                            state <= S_DRAIN;
                            dcnt  <= '0;
                        end else begin
                            s <= s + SW'(1);
                            j <= '0;
                        end
                    end else begin
                        j <= j + LOG2N'(1);
                    end
                end
                S_DRAIN: begin
                    if (d_last) begin
                        if (!mode_q && !s_last) begin
                            state <= S_RUN;
                            s     <= s + SW'(1);
                            j     <= '0;
                        end else begin
                            state <= S_DONE;
                        end
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Write-back delay line matching the datapath latency; frozen while en is low
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                vld_sr[i] <= 1'b0;
                a_sr[i]   <= '0;
                b_sr[i]   <= '0;
            end
        end else if (en) begin
            vld_sr[0] <= rd_valid;
            a_sr[0]   <= addr_A;
            b_sr[0]   <= addr_B;
            for (int i = 1; i < PIPE_LAT; i++) begin
                vld_sr[i] <= vld_sr[i-1];
                a_sr[i]   <= a_sr[i-1];
                b_sr[i]   <= b_sr[i-1];
            end
        end
    end

    assign wr_en     = vld_sr[PIPE_LAT-1];
    assign wr_addr_A = a_sr[PIPE_LAT-1];
    assign wr_addr_B = b_sr[PIPE_LAT-1];

endmodule

// File: tb/tb_fft_agu_sched.sv
// tb/tb_fft_agu_sched.sv - directed self-checking bench for fft_agu_sched
module tb_fft_agu_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic mode_v;
    logic start_v [3];
    logic en_v    [3];
    logic rstn_v  [3];

    logic       busy0, rdv0, we0, done0;
    logic [4:0] a0, b0, wa0, wb0;
    logic [3:0] tw0;
    logic [2:0] st0;

    logic       busy1, rdv1, we1, done1;
    logic [4:0] a1, b1, wa1, wb1;
    logic [3:0] tw1;
    logic [2:0] st1;

    logic       busy2, rdv2, we2, done2;
    logic [9:0] a2, b2, wa2, wb2;
    logic [8:0] tw2;
    logic [3:0] st2;

    fft_agu_sched #(.LOG2N(5), .PIPE_LAT(3), .HAZARD_WAIT(1)) u_dut (
        .clk(clk), .reset(rstn_v[0]), .start(start_v[0]), .mode(mode_v), .en(en_v[0]),
        .busy(busy0), .rd_valid(rdv0), .addr_A(a0), .addr_B(b0), .addr_Tw(tw0),
        .stage(st0), .wr_en(we0), .wr_addr_A(wa0), .wr_addr_B(wb0), .done(done0)
    );

    fft_agu_sched #(.LOG2N(5), .PIPE_LAT(3), .HAZARD_WAIT(0)) u_hw0 (
        .clk(clk), .reset(rstn_v[1]), .start(start_v[1]), .mode(mode_v), .en(en_v[1]),
        .busy(busy1), .rd_valid(rdv1), .addr_A(a1), .addr_B(b1), .addr_Tw(tw1),
        .stage(st1), .wr_en(we1), .wr_addr_A(wa1), .wr_addr_B(wb1), .done(done1)
    );

    fft_agu_sched #(.LOG2N(10), .PIPE_LAT(1), .HAZARD_WAIT(1)) u_big (
        .clk(clk), .reset(rstn_v[2]), .start(start_v[2]), .mode(mode_v), .en(en_v[2]),
        .busy(busy2), .rd_valid(rdv2), .addr_A(a2), .addr_B(b2), .addr_Tw(tw2),
        .stage(st2), .wr_en(we2), .wr_addr_A(wa2), .wr_addr_B(wb2), .done(done2)
    );

    int   sel;
    logic m_busy, m_rdv, m_we, m_done;
    int   m_a, m_b, m_tw, m_st, m_wa, m_wb;

    always_comb begin
        m_busy = 1'b0; m_rdv = 1'b0; m_we = 1'b0; m_done = 1'b0;
        m_a = 0; m_b = 0; m_tw = 0; m_st = 0; m_wa = 0; m_wb = 0;
        case (sel)
            0: begin
                m_busy = busy0; m_rdv = rdv0; m_we = we0; m_done = done0;
                m_a = int'(a0); m_b = int'(b0); m_tw = int'(tw0); m_st = int'(st0);
                m_wa = int'(wa0); m_wb = int'(wb0);
            end
            1: begin
                m_busy = busy1; m_rdv = rdv1; m_we = we1; m_done = done1;
                m_a = int'(a1); m_b = int'(b1); m_tw = int'(tw1); m_st = int'(st1);
                m_wa = int'(wa1); m_wb = int'(wb1);
            end
            2: begin
                m_busy = busy2; m_rdv = rdv2; m_we = we2; m_done = done2;
                m_a = int'(a2); m_b = int'(b2); m_tw = int'(tw2); m_st = int'(st2);
                m_wa = int'(wa2); m_wb = int'(wb2);
            end
            default: ;
        endcase
    end

    int rd_a[$], rd_b[$], rd_tw[$], rd_st[$], rd_cyc[$];
    int wr_a[$], wr_b[$], wr_cyc[$];
    int ref_a[$], ref_b[$], ref_tw[$];
    int done_cyc;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic check_wr(input string tag, input int lat);
        int errs = 0;
        check({tag, "_wr_count"}, wr_a.size(), rd_a.size());
        for (int k = 0; k < rd_a.size() && k < wr_a.size(); k++) begin
            if (wr_a[k] != rd_a[k] || wr_b[k] != rd_b[k] || wr_cyc[k] != rd_cyc[k] + lat)
                errs++;
        end
        check({tag, "_wr_follows_rd"}, errs, 0);
    endtask

    // One full transform on instance 'which'; cycles are counted only when en is high
    task automatic run_xform(input int which, input bit md, input bit rnd, input int limit);
        int cyc;
        bit fin, held, e, prev_e, prev_done;
        sel = which;
        rd_a.delete(); rd_b.delete(); rd_tw.delete(); rd_st.delete(); rd_cyc.delete();
        wr_a.delete(); wr_b.delete(); wr_cyc.delete();
        done_cyc = -1;
        @(negedge clk);
        mode_v = md; start_v[which] = 1'b1; en_v[which] = 1'b1;
        @(negedge clk);
        start_v[which] = 1'b0;
        check("first_rd_valid", int'(m_rdv), 1);
        cyc = 1; fin = 0; held = 0; prev_e = 1; prev_done = 0;
        while (!fin && cyc <= limit) begin
            if (!prev_e && prev_done) begin
                check("done_hold", int'(m_done), 1);
                check("busy_hold_at_done", int'(m_busy), 1);
            end
            e = 1'b1;
            if (rnd) e = ($urandom_range(0, 3) != 0);
            if (rnd && m_done && !held) begin
                e = 1'b0;
                held = 1'b1;
            end
            en_v[which] = e;
            if (e) begin
                if (m_rdv) begin
                    rd_a.push_back(m_a); rd_b.push_back(m_b); rd_tw.push_back(m_tw);
                    rd_st.push_back(m_st); rd_cyc.push_back(cyc);
                end
                if (m_we) begin
                    wr_a.push_back(m_wa); wr_b.push_back(m_wb); wr_cyc.push_back(cyc);
                end
                if (m_done) begin
                    done_cyc = cyc;
                    fin = 1'b1;
                end
                cyc++;
            end
            prev_e = e;
            prev_done = m_done;
            @(negedge clk);
        end
        en_v[which] = 1'b1;
        check("completed_in_budget", int'(fin), 1);
    endtask

    initial begin
        int cnt, errs, we_seen;
        sel = 0; mode_v = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0; en_v[i] = 1'b0; rstn_v[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        check("rst_busy", int'(m_busy), 0);
        check("rst_rd_valid", int'(m_rdv), 0);
        for (int i = 0; i < 3; i++) rstn_v[i] = 1'b1;
        @(negedge clk);
        check("idle_wr_en_done", int'(m_we) + int'(m_done), 0);
        check("idle_addr_A", m_a, 0);
        check("idle_addr_B", m_b, 0);
        check("idle_stage_tw", m_st + m_tw, 0);
        check("idle_wr_addr", m_wa + m_wb, 0);

        // default FFT run, en held high
        run_xform(0, 1'b0, 1'b0, 200);
        check("s0j0_A", at(rd_a, 0), 0);
        check("s0j0_B", at(rd_b, 0), 1);
        check("s0j0_Tw", at(rd_tw, 0), 0);
        check("s2j5_A", at(rd_a, 2*16+5), 9);
        check("s2j5_B", at(rd_b, 2*16+5), 13);
        check("s2j5_Tw", at(rd_tw, 2*16+5), 4);
        check("s2j5_stage", at(rd_st, 2*16+5), 2);
        check("s4j5_A", at(rd_a, 4*16+5), 5);
        check("s4j5_B", at(rd_b, 4*16+5), 21);
        check("s4j5_Tw", at(rd_tw, 4*16+5), 5);
        for (int s = 0; s < 5; s++) begin
            cnt = 0;
            foreach (rd_st[k]) if (rd_st[k] == s) cnt++;
            check($sformatf("rd_per_stage%0d", s), cnt, 16);
        end
        check("stage1_first_rd_cycle", at(rd_cyc, 16), 20);
        check("default_done_cycle", done_cyc, 96);
        check("default_wr_total", wr_a.size(), 80);
        check_wr("default", 3);
        ref_a = rd_a; ref_b = rd_b; ref_tw = rd_tw;

        // same transform with random en gaps
        run_xform(0, 1'b0, 1'b1, 1000);
        check("stall_rd_count", rd_a.size(), ref_a.size());
        errs = 0;
        for (int k = 0; k < rd_a.size() && k < ref_a.size(); k++)
            if (rd_a[k] != ref_a[k] || rd_b[k] != ref_b[k] || rd_tw[k] != ref_tw[k]) errs++;
        check("stall_addr_sequence", errs, 0);
        check("stall_wr_total", wr_a.size(), 80);
        check("stall_done_cycle", done_cyc, 96);
        check_wr("stall", 3);

        // bit-reverse copy pass
        run_xform(0, 1'b1, 1'b0, 200);
        check("copy_rd_count", rd_a.size(), 32);
        check("copy_j1_B", at(rd_b, 1), 16);
        check("copy_j6_A", at(rd_a, 6), 6);
        check("copy_j6_B", at(rd_b, 6), 12);
        check("copy_j31_B", at(rd_b, 31), 31);
        cnt = 0;
        foreach (rd_tw[k]) cnt += rd_tw[k] + rd_st[k];
        check("copy_tw_stage_zero", cnt, 0);
        check("copy_wr_total", wr_a.size(), 32);
        check("copy_done_cycle", done_cyc, 36);
        check_wr("copy", 3);

        // asynchronous reset at stage 2, j = 7 (cycle 2*19 + 8 = 46)
        sel = 0;
        @(negedge clk);
        mode_v = 1'b0; start_v[0] = 1'b1; en_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (45) @(negedge clk);
        check("pre_rst_stage", m_st, 2);
        check("pre_rst_A", m_a, 11);
        check("pre_rst_B", m_b, 15);
        check("pre_rst_Tw", m_tw, 12);
        #2 rstn_v[0] = 1'b0;
        #1;
        check("arst_busy_rdv_we_done", int'(m_busy) + int'(m_rdv) + int'(m_we) + int'(m_done), 0);
        check("arst_addr", m_a + m_b + m_tw + m_st, 0);
        check("arst_wr_addr", m_wa + m_wb, 0);
        repeat (2) @(negedge clk);
        rstn_v[0] = 1'b1;
        we_seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (m_we || m_busy) we_seen++;
        end
        check("post_rst_quiet", we_seen, 0);
        run_xform(0, 1'b0, 1'b0, 200);
        check("restart_A", at(rd_a, 0), 0);
        check("restart_B", at(rd_b, 0), 1);
        check("restart_stage", at(rd_st, 0), 0);
        check("restart_done_cycle", done_cyc, 96);

        // HAZARD_WAIT = 0: stages issue back to back
        run_xform(1, 1'b0, 1'b0, 200);
        check("hw0_rd_count", rd_a.size(), 80);
        errs = 0;
        foreach (rd_cyc[k]) if (rd_cyc[k] != k + 1) errs++;
        check("hw0_no_gap", errs, 0);
        check("hw0_stage1_j0_B", at(rd_b, 16), 2);
        check("hw0_wr_total", wr_a.size(), 80);
        check("hw0_done_cycle", done_cyc, 84);
        check_wr("hw0", 3);

        // LOG2N = 10, PIPE_LAT = 1
        run_xform(2, 1'b0, 1'b0, 6000);
        check("big_s9j511_A", at(rd_a, 5119), 511);
        check("big_s9j511_B", at(rd_b, 5119), 1023);
        check("big_s9j511_Tw", at(rd_tw, 5119), 511);
        check("big_s9j511_stage", at(rd_st, 5119), 9);
        check("big_done_cycle", done_cyc, 5131);
        check_wr("big", 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
